// File: rtl/div_clk_monitor_if.sv
// Bundle between a divider output checker and its driver: enable/div_clk in, measurements out.
interface div_clk_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             div_clk;
    logic [CNT_W-1:0] period_len;
    logic [CNT_W-1:0] high_len;
    logic             period_valid;
    logic             period_err;
    logic             duty_err;
    logic             locked;
    logic [7:0]       err_count;

    modport master (
        output enable, div_clk,
        input  period_len, high_len, period_valid, period_err, duty_err, locked, err_count
    );

    modport slave (
        input  enable, div_clk,
        output period_len, high_len, period_valid, period_err, duty_err, locked, err_count
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures period/high phase of a divided clock sampled in clk and tracks lock and errors.
// Optional high-phase (duty) checking is enabled by defining DIV_MON_DUTY_CHECK_EN.
module div_clk_monitor #(
    parameter int DIV          = 4,
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                clk,
    input  logic                reset,
    div_clk_monitor_if.slave    mon
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(DIV);
    localparam logic [3:0]       LOCK_TOP = 4'(LOCK_PERIODS - 1);

    logic [1:0]       state_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       good_cnt_reg;
    logic [CNT_W-1:0] period_len_reg;
    logic             period_valid_reg;
    logic             period_err_reg;
    logic             locked_reg;
    logic [7:0]       err_count_reg;
    logic [7:0]       err_count_next;

    logic rise;
    logic active;
    logic capture;
    logic cnt_sat;
    logic period_ok;
    logic duty_ok;
    logic good;

    assign rise      = mon.div_clk & ~prev_reg;
    assign active    = (state_reg == ST_MEASURE) || (state_reg == ST_LOCKED);
    assign capture   = mon.enable && active && rise;
    assign cnt_sat   = (cnt_reg == CNT_MAX);
    assign period_ok = (cnt_reg == DIV_C);
    assign good      = period_ok && duty_ok;
    assign cnt_next  = rise ? CNT_ONE : (cnt_sat ? cnt_reg : cnt_reg + CNT_ONE);
    assign err_count_next = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

`ifdef DIV_MON_DUTY_CHECK_EN
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] high_len_reg;
    logic             duty_err_reg;

    assign duty_ok = (hcnt_reg == HALF_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_reg     <= '0;
            high_len_reg <= '0;
            duty_err_reg <= 1'b0;
        end else begin
            duty_err_reg <= 1'b0;
            if (!mon.enable) begin
                hcnt_reg <= '0;
            end else begin
                if (rise)
                    hcnt_reg <= CNT_ONE;
                else if (mon.div_clk && hcnt_reg != CNT_MAX)
                    hcnt_reg <= hcnt_reg + CNT_ONE;
                if (capture) begin
                    high_len_reg <= hcnt_reg;
                    duty_err_reg <= ~duty_ok;
                end
            end
        end
    end

    assign mon.high_len = high_len_reg;
    assign mon.duty_err = duty_err_reg;
`else
    assign duty_ok      = 1'b1;
    assign mon.high_len = '0;
    assign mon.duty_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            prev_reg         <= 1'b0;
            cnt_reg          <= '0;
            good_cnt_reg     <= '0;
            period_len_reg   <= '0;
            period_valid_reg <= 1'b0;
            period_err_reg   <= 1'b0;
            locked_reg       <= 1'b0;
            err_count_reg    <= '0;
        end else begin
            prev_reg         <= mon.div_clk;
            period_valid_reg <= 1'b0;
            period_err_reg   <= 1'b0;
            if (!mon.enable) begin
                state_reg    <= ST_IDLE;
                cnt_reg      <= '0;
                good_cnt_reg <= '0;
                locked_reg   <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                case (state_reg)
                    ST_IDLE: state_reg <= ST_WAIT;
                    ST_WAIT: if (rise) state_reg <= ST_MEASURE;
                    default: begin
                        // A rise coinciding with saturation is measured, not timed out.
                        if (rise) begin
                            period_len_reg   <= cnt_reg;
                            period_valid_reg <= 1'b1;
                            period_err_reg   <= ~period_ok;
                            if (good) begin
                                if (state_reg == ST_MEASURE) begin
                                    good_cnt_reg <= good_cnt_reg + 4'd1;
                                    if (good_cnt_reg == LOCK_TOP) begin
                                        state_reg  <= ST_LOCKED;
                                        locked_reg <= 1'b1;
                                    end
                                end
                            end else begin
                                good_cnt_reg  <= '0;
                                locked_reg    <= 1'b0;
                                state_reg     <= ST_MEASURE;
                                err_count_reg <= err_count_next;
                            end
                        end else if (cnt_sat) begin
                            period_err_reg <= 1'b1;
                            err_count_reg  <= err_count_next;
                            good_cnt_reg   <= '0;
                            locked_reg     <= 1'b0;
                            state_reg      <= ST_WAIT;
                        end
                    end
                endcase
            end
        end
    end

    assign mon.period_len   = period_len_reg;
    assign mon.period_valid = period_valid_reg;
    assign mon.period_err   = period_err_reg;
    assign mon.locked       = locked_reg;
    assign mon.err_count    = err_count_reg;
endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Checker stage that sits directly downstream of the even frequency divider and consumes its divided-clock output as a data signal in the `clk` domain. It measures each divided-clock period and high-phase length in `clk` cycles and compares them against the expected ratio `DIV`. It declares lock after `LOCK_PERIODS` consecutive good periods and flags and counts period, duty and timeout errors. It is used in bring-up benches and as a built-in self-check behind every divider instance.

## Interface
- `DIV`, 4: expected division ratio; even, ≥2; expected high phase is `DIV/2`.
- `CNT_W`, 8: width of the period and high-phase counters; must satisfy `2^CNT_W-1 > DIV`.
- `LOCK_PERIODS`, 4: consecutive good periods required to assert `locked`; range 1..15.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: monitor enable; when low, the block is held in IDLE.
- `div_clk` input 1: divider output, already synchronous to `clk`.
- `period_len` output CNT_W: last measured period in `clk` cycles.
- `high_len` output CNT_W: last measured high-phase length in `clk` cycles.
- `period_valid` output 1: one-cycle pulse; `period_len` and `high_len` updated.
- `period_err` output 1: one-cycle pulse; period ≠ `DIV`, or timeout.
- `duty_err` output 1: one-cycle pulse; `high_len` ≠ `DIV/2`.
- `locked` output 1: level; lock achieved and held.
- `err_count` output 8: saturating count of erroneous periods.

## Operation
- Edge detect: `prev` register holds the previous `div_clk` sample. `rise = div_clk & ~prev`.
- Period counter `cnt`:
  - on `rise`, `cnt <= 1`;
  - otherwise `cnt` increments and saturates at `2^CNT_W-1`.
- High counter `hcnt`:
  - on `rise`, `hcnt <= 1`;
  - otherwise `hcnt` increments while `div_clk=1` and holds while `div_clk=0`.
- States:
  - IDLE: entered on reset or `enable=0`. Moves to WAIT_RISE when `enable=1`.
  - WAIT_RISE: the first `rise` arms the counters and moves to MEASURE. No `period_valid` is produced for this rise.
  - MEASURE: on each `rise`, capture `period_len <= cnt` and `high_len <= hcnt`, and pulse `period_valid`.
    - Good period (both values match): increment `good_cnt`. When `good_cnt` reaches `LOCK_PERIODS`, go to LOCKED.
    - Bad period: clear `good_cnt` and stay in MEASURE.
  - LOCKED: `locked=1`. Any bad period clears `locked` and `good_cnt` and returns to MEASURE.
- Timeout: if `cnt` reaches saturation in MEASURE or LOCKED:
  - pulse `period_err` once;
  - increment `err_count`;
  - clear `locked` and `good_cnt`;
  - go to WAIT_RISE.
- `err_count` increments by exactly 1 per erroneous period, even when both `period_err` and `duty_err` fire. It saturates at 255 and is cleared only by `reset`.
- `enable` falling: go to IDLE and clear `locked`, `good_cnt`, `cnt`, `hcnt` and all pulses. `period_len`, `high_len` and `err_count` hold.

## Timing
- Reset values: all outputs 0, state IDLE, `prev=0`.
- All outputs are registered and change on the `clk` edge that samples `rise`. Latency is 1 cycle from the `div_clk` 0→1 transition appearing at the input to `period_valid`.
- `period_err` and `duty_err` are coincident with `period_valid`. The timeout `period_err` has no accompanying `period_valid`.
- `locked` rises in the same cycle as the `LOCK_PERIODS`-th good `period_valid`.
- Simultaneous events:
  - `rise` and counter saturation in the same cycle: `rise` wins and the period is measured as saturated, i.e. a period error.
  - `enable=0` and `rise` in the same cycle: `enable` wins and there is no capture.
  - `reset` mid-period: all state and outputs are cleared on that edge.

## Configuration
- `DIV_MON_DUTY_CHECK_EN` defined: high-phase measurement and `duty_err` are active, and a good period requires correct period and correct high phase.
- `DIV_MON_DUTY_CHECK_EN` undefined:
  - `hcnt` is removed;
  - `high_len` and `duty_err` are tied to 0;
  - lock and `err_count` depend on period only.

## Test plan
- DIV=4, ideal /4 input (2 high, 2 low) after reset release, `enable=1`:
  - first `period_valid` occurs on the 2nd rise, with `period_len=4` and `high_len=2`;
  - `locked=1` on the 4th `period_valid`;
  - `err_count=0`.
- Locked, then one period stretched to 5 cycles → `period_err` pulse with `period_len=5`, `locked` falls, `err_count=1`; `locked` returns after 4 further good periods.
- Locked, then a 3-high/1-low period (macro defined) → `duty_err` pulse with `high_len=3`, `period_err=0`, `err_count=1`. With the macro undefined: no error and `locked` stays 1.
- `div_clk` stuck low after lock, CNT_W=4 → one `period_err` at `cnt=15`, then WAIT_RISE, `locked=0`. A later good input re-locks.
- Drop `enable` mid-period while locked → `locked=0` on the next edge, `period_len=4` held. Re-enable → no `period_valid` until the 2nd rise.
- Force 300 bad periods → `err_count` saturates at 255. Assert `reset` mid-period → all outputs 0 on the next edge.
